// File: rtl/fwd_sel_ctrl_pkg.sv
// Shared constants for the EX-stage operand forwarding controller:
// mux select encodings and the per-edge pipeline advance action.
package fwd_sel_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_WBL   = 2'b11;

  typedef enum logic [1:0] {
    ADV_HOLD,
    ADV_BUBBLE,
    ADV_NORMAL
  } adv_e;

endpackage

// File: rtl/fwd_src_pick.sv
// Priority compare of one source register against the EX/MEM/WB slots;
// the youngest writing slot wins, and $0 never forwards.
module fwd_src_pick
  import fwd_sel_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [2:0]        valid,
  input  logic [2:0]        wr,
  input  logic [REG_AW-1:0] dst_ex,
  input  logic [REG_AW-1:0] dst_mem,
  input  logic [REG_AW-1:0] dst_wb,
  output logic [1:0]        sel
);

  // Oldest slot is tested first so a younger match overwrites it.
  always_comb begin
    sel = FWD_RF;
    if (src != '0) begin
      if (valid[2] && wr[2] && (dst_wb == src))  sel = FWD_WBL;
      if (valid[1] && wr[1] && (dst_mem == src)) sel = FWD_MEMWB;
      if (valid[0] && wr[0] && (dst_ex == src))  sel = FWD_EXMEM;
    end
  end

endmodule

// File: rtl/fwd_sel_ctrl.sv
// Forwarding select and load-use stall controller for the 5-stage pipe:
// tracks in-flight destinations and registers both EX operand selects.
module fwd_sel_ctrl
  import fwd_sel_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_id_valid_1,
  input  logic [REG_AW-1:0] w_id_rs_5,
  input  logic [REG_AW-1:0] w_id_rt_5,
  input  logic              w_id_wr_1,
  input  logic [REG_AW-1:0] w_id_dst_5,
  input  logic              w_id_load_1,
  input  logic              w_hold_1,
  input  logic              w_flush_1,
  output logic [1:0]        w_sel_a_2,
  output logic [1:0]        w_sel_b_2,
  output logic              w_stall_1
);

  // The load flag only matters while a slot is in EX, so only EX keeps it.
  logic              ex_valid, ex_wr, ex_load;
  logic [REG_AW-1:0] ex_dst;
  logic              mem_valid, mem_wr;
  logic [REG_AW-1:0] mem_dst;
  logic              wb_valid, wb_wr;
  logic [REG_AW-1:0] wb_dst;

  logic [1:0] pick_a, pick_b;
  adv_e       adv;

  assign w_stall_1 = ex_valid & ex_load & ex_wr & (ex_dst != '0) & w_id_valid_1
                   & ((ex_dst == w_id_rs_5) | (ex_dst == w_id_rt_5)) & ~w_flush_1;

  always_comb begin
    adv = ADV_NORMAL;
    if (w_hold_1)
      adv = ADV_HOLD;
    else if (w_flush_1 || w_stall_1)
      adv = ADV_BUBBLE;
  end

  fwd_src_pick #(.REG_AW(REG_AW)) u_pick_a (
    .src     (w_id_rs_5),
    .valid   ({wb_valid, mem_valid, ex_valid}),
    .wr      ({wb_wr, mem_wr, ex_wr}),
    .dst_ex  (ex_dst),
    .dst_mem (mem_dst),
    .dst_wb  (wb_dst),
    .sel     (pick_a)
  );

  fwd_src_pick #(.REG_AW(REG_AW)) u_pick_b (
    .src     (w_id_rt_5),
    .valid   ({wb_valid, mem_valid, ex_valid}),
    .wr      ({wb_wr, mem_wr, ex_wr}),
    .dst_ex  (ex_dst),
    .dst_mem (mem_dst),
    .dst_wb  (wb_dst),
    .sel     (pick_b)
  );

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      ex_valid  <= 1'b0;
      ex_wr     <= 1'b0;
      ex_load   <= 1'b0;
      ex_dst    <= '0;
      mem_valid <= 1'b0;
      mem_wr    <= 1'b0;
      mem_dst   <= '0;
      wb_valid  <= 1'b0;
      wb_wr     <= 1'b0;
      wb_dst    <= '0;
      w_sel_a_2 <= FWD_RF;
      w_sel_b_2 <= FWD_RF;
    end else if (adv != ADV_HOLD) begin
      wb_valid  <= mem_valid;
      wb_wr     <= mem_wr;
      wb_dst    <= mem_dst;
      mem_valid <= ex_valid;
      mem_wr    <= ex_wr;
      mem_dst   <= ex_dst;
      if (adv == ADV_BUBBLE) begin
        ex_valid  <= 1'b0;
        ex_wr     <= 1'b0;
        ex_load   <= 1'b0;
        ex_dst    <= '0;
        w_sel_a_2 <= FWD_RF;
        w_sel_b_2 <= FWD_RF;
      end else begin
        ex_valid  <= w_id_valid_1;
        ex_wr     <= w_id_wr_1;
        ex_load   <= w_id_load_1;
        ex_dst    <= w_id_dst_5;
        w_sel_a_2 <= w_id_valid_1 ? pick_a : FWD_RF;
        w_sel_b_2 <= w_id_valid_1 ? pick_b : FWD_RF;
      end
    end
  end

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Table-driven bench for fwd_sel_ctrl: each row is one cycle of ID/control
// inputs plus the selects and stall expected during that cycle.
module tb_fwd_sel_ctrl;

  logic       w_clk;
  logic       w_rst;
  logic       w_id_valid_1;
  logic [4:0] w_id_rs_5;
  logic [4:0] w_id_rt_5;
  logic       w_id_wr_1;
  logic [4:0] w_id_dst_5;
  logic       w_id_load_1;
  logic       w_hold_1;
  logic       w_flush_1;
  logic [1:0] w_sel_a_2;
  logic [1:0] w_sel_b_2;
  logic       w_stall_1;

  typedef struct {
    logic       rst, hold, flush, valid, wr, load;
    logic [4:0] dst, rs, rt;
    logic [1:0] exp_a, exp_b;
    logic       exp_stall;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   passed = 0;

  fwd_sel_ctrl #(.REG_AW(5)) dut (
    .w_clk        (w_clk),
    .w_rst        (w_rst),
    .w_id_valid_1 (w_id_valid_1),
    .w_id_rs_5    (w_id_rs_5),
    .w_id_rt_5    (w_id_rt_5),
    .w_id_wr_1    (w_id_wr_1),
    .w_id_dst_5   (w_id_dst_5),
    .w_id_load_1  (w_id_load_1),
    .w_hold_1     (w_hold_1),
    .w_flush_1    (w_flush_1),
    .w_sel_a_2    (w_sel_a_2),
    .w_sel_b_2    (w_sel_b_2),
    .w_stall_1    (w_stall_1)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  function automatic vec_t mk(input int rst, hold, flush, valid, wr, load,
                              input int dst, rs, rt, ea, eb, es);
    vec_t v;
    v.rst = rst[0];     v.hold = hold[0];  v.flush = flush[0];
    v.valid = valid[0]; v.wr = wr[0];      v.load = load[0];
    v.dst = dst[4:0];   v.rs = rs[4:0];    v.rt = rt[4:0];
    v.exp_a = ea[1:0];  v.exp_b = eb[1:0]; v.exp_stall = es[0];
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    w_rst        = v.rst;
    w_hold_1     = v.hold;
    w_flush_1    = v.flush;
    w_id_valid_1 = v.valid;
    w_id_wr_1    = v.wr;
    w_id_load_1  = v.load;
    w_id_dst_5   = v.dst;
    w_id_rs_5    = v.rs;
    w_id_rt_5    = v.rt;
  endtask

  task automatic checkOne(input string name, input int row,
                          input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act === exp)
      passed++;
    else
      $display("[TB] FAIL %s row %0d: got %b, expected %b", name, row, act, exp);
  endtask

  task automatic checkOutput(input int row, input vec_t v);
    checkOne("sel_a", row, w_sel_a_2, v.exp_a);
    checkOne("sel_b", row, w_sel_b_2, v.exp_b);
    checkOne("stall", row, {1'b0, w_stall_1}, {1'b0, v.exp_stall});
  endtask

  initial begin
    //                rst hld fl  val wr  ld  dst rs  rt  ea eb st
    // reset state
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0));
    // add $3 then consumer of $3: EX/MEM, then WB latch / MEM/WB
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  3,  1,  2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  4,  3,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0,  0,  0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  0,  3,  4, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0,  0,  0, 3, 2, 0));
    // lw $5 then rt=$5 user: one stall, then MEM/WB select
    tbl.push_back(mk(0, 0, 0, 1, 1, 1,  5,  1,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  6,  2,  5, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  6,  2,  5, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 2, 0));
    // $0 destinations and sources never forward or stall
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1,  0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0));
    // two producers of $7: the newer one wins
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  7,  1,  1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  7,  7,  2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  0,  7,  7, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  0,  7,  0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0,  0,  0, 2, 0, 0));
    // flush while a load-use hazard is present
    tbl.push_back(mk(0, 0, 0, 1, 1, 1,  8,  0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0,  9,  8,  8, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  9,  8,  1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0,  0,  0, 2, 0, 0));
    // hold for 3 cycles with a pending stall, then reset mid-stall
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 10,  9,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 11, 10,  9, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 12, 11,  0, 1, 3, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 12, 11,  0, 1, 3, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 12,  0,  0, 1, 3, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 12, 11, 10, 1, 3, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 12, 11, 10, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  0, 12, 12, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0,  0,  0, 1, 1, 0));

    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge w_clk);
    #1;

    // Inputs change 1 unit after the rising edge; outputs sampled 3 units later.
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      #3;
      checkOutput(i, tbl[i]);
      @(posedge w_clk);
      #1;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
